// File: rtl/btn_pkg.sv
// btn_pkg: shared defaults and helpers for the button conditioner.
// Contents:
//   DEF_*        default parameter values for button_conditioner / btn_channel
//   MAX_N_CH     largest supported channel count
//   ctr_width()  bit width needed to hold a counter's terminal value
package btn_pkg;

  localparam int unsigned DEF_N_CH         = 5;
  localparam int unsigned DEF_DEBOUNCE_CYC = 500_000;
  localparam int unsigned DEF_HOLD_CYC     = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYC   = 10_000_000;
  localparam int unsigned MAX_N_CH         = 32;

  // Width of a counter that must reach 'max' without wrapping.
  function automatic int unsigned ctr_width(input int unsigned max);
    return 32'($clog2(64'(max) + 64'd1));
  endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button channel -- 2-flop synchronizer, debounce,
// press/release edge pulses, long-hold detection and optional auto-repeat.
// Configuration macro: BTN_AUTOREPEAT_EN (defined -> repeat_o active,
// undefined -> no repeat counter, repeat_o tied to 0).
// Ports:
//   clk_i      clock, all flops on the rising edge
//   rst_i      asynchronous active-high reset
//   btn_i      raw asynchronous button input
//   level_o    debounced level
//   press_o    one-cycle pulse when level_o rises
//   release_o  one-cycle pulse when level_o falls
//   long_o     one-cycle pulse after level_o has been high HOLD_CYC cycles
//   repeat_o   one-cycle pulse every REPEAT_CYC cycles after long_o
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
  parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int unsigned DW = ctr_width(DEBOUNCE_CYC);
  localparam int unsigned HW = ctr_width(HOLD_CYC);

  // Parameter sanity: elaboration stops on an unusable configuration.
  if (DEBOUNCE_CYC == 0) begin : g_bad_debounce
    $error("btn_channel: DEBOUNCE_CYC must be nonzero");
  end
  if (HOLD_CYC == 0) begin : g_bad_hold
    $error("btn_channel: HOLD_CYC must be nonzero");
  end
  if (REPEAT_CYC == 0) begin : g_bad_repeat
    $error("btn_channel: REPEAT_CYC must be nonzero");
  end
  if (HOLD_CYC <= DEBOUNCE_CYC) begin : g_bad_order
    $error("btn_channel: HOLD_CYC must exceed DEBOUNCE_CYC");
  end

  logic          sync_q1;
  logic          sync_q2;
  logic          prev_q;
  logic [DW-1:0] db_ctr;
  logic [HW-1:0] hold_ctr;

  logic db_done_c;
  logic rise_c;
  logic fall_c;
  logic hold_run_c;
  logic hold_sat_c;

  // Debounce is complete once the sample has been stable long enough;
  // the level then follows the stable sample if it differs.
  assign db_done_c  = (db_ctr == DW'(DEBOUNCE_CYC));
  assign rise_c     = db_done_c &  prev_q & ~level_o;
  assign fall_c     = db_done_c & ~prev_q &  level_o;
  // Hold keeps counting only while the level stays high through this edge,
  // so a release clears it in the same cycle release_o is raised.
  assign hold_run_c = level_o & ~fall_c;
  assign hold_sat_c = (hold_ctr == HW'(HOLD_CYC));

  // Synchronizer, debounce counter, debounced level and edge pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      prev_q    <= 1'b0;
      db_ctr    <= '0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      sync_q1 <= btn_i;
      sync_q2 <= sync_q1;
      if (sync_q2 != prev_q) begin
        prev_q <= sync_q2;
        db_ctr <= '0;
      end else if (!db_done_c) begin
        db_ctr <= db_ctr + DW'(1);
      end
      if (rise_c || fall_c) begin
        level_o <= prev_q;
      end
      press_o   <= rise_c;
      release_o <= fall_c;
    end
  end

  // Hold counter: zero while released (and on the press edge), saturates at HOLD_CYC.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_ctr <= '0;
      long_o   <= 1'b0;
    end else begin
      if (!hold_run_c) begin
        hold_ctr <= '0;
      end else if (!hold_sat_c) begin
        hold_ctr <= hold_ctr + HW'(1);
      end
      long_o <= hold_run_c && (hold_ctr == HW'(HOLD_CYC - 1));
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RW = ctr_width(REPEAT_CYC);

  logic [RW-1:0] rep_ctr;

  // Repeat phase starts the cycle after long_o; a pulse every REPEAT_CYC cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rep_ctr  <= '0;
      repeat_o <= 1'b0;
    end else begin
      if (!(hold_run_c && hold_sat_c)) begin
        rep_ctr  <= '0;
        repeat_o <= 1'b0;
      end else if (rep_ctr == RW'(REPEAT_CYC - 1)) begin
        rep_ctr  <= '0;
        repeat_o <= 1'b1;
      end else begin
        rep_ctr  <= rep_ctr + RW'(1);
        repeat_o <= 1'b0;
      end
    end
  end
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: N_CH independent debounced button channels with
// press/release/long-hold pulses and optional auto-repeat.
// Configuration macro: BTN_AUTOREPEAT_EN (enables repeat_o pulses).
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   btn_i      [N_CH] raw asynchronous button inputs
//   level_o    [N_CH] debounced levels
//   press_o    [N_CH] debounced rising-edge pulses
//   release_o  [N_CH] debounced falling-edge pulses
//   long_o     [N_CH] long-hold pulses
//   repeat_o   [N_CH] auto-repeat pulses (0 unless BTN_AUTOREPEAT_EN)
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_CH         = DEF_N_CH,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
  parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_o,
  output logic [N_CH-1:0] repeat_o
);

  if (N_CH == 0 || N_CH > MAX_N_CH) begin : g_bad_n_ch
    $error("button_conditioner: N_CH must be in 1..32");
  end

  // One self-contained conditioner per button.
  for (genvar ch = 0; ch < int'(N_CH); ch++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
    ) u_channel (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .btn_i     (btn_i[ch]),
      .level_o   (level_o[ch]),
      .press_o   (press_o[ch]),
      .release_o (release_o[ch]),
      .long_o    (long_o[ch]),
      .repeat_o  (repeat_o[ch])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner (N_CH=3, DEBOUNCE_CYC=8, HOLD_CYC=40, REPEAT_CYC=10).
module tb_button_conditioner;

  localparam int N_CH = 3;
  localparam int DEB  = 8;
  localparam int HOLD = 40;
  localparam int REP  = 10;
  localparam int LAT  = DEB + 4;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N_CH-1:0] btn_i;
  logic [N_CH-1:0] level_o, press_o, release_o, long_o, repeat_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  button_conditioner #(
    .N_CH(N_CH), .DEBOUNCE_CYC(DEB), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_i),
    .level_o(level_o), .press_o(press_o), .release_o(release_o),
    .long_o(long_o), .repeat_o(repeat_o)
  );

  // Reference model: the level follows the raw input once the raw sample
  // seen 3 edges ago has matched the previous DEB samples; hold time is the
  // number of edges since the press.
  logic [N_CH-1:0] hist[$];
  int              held[N_CH];
  logic [N_CH-1:0] m_level, m_press, m_release, m_long, m_repeat;

  function automatic logic win_bit(input int c, input logic cur);
    int   k = hist.size();
    logic v;
    if (k < LAT) return cur;
    v = hist[k-4][c];
    for (int i = k - 4 - DEB; i < k - 4; i++)
      if (hist[i][c] != v) return cur;
    return v;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist.delete();
      m_level   <= '0;
      m_press   <= '0;
      m_release <= '0;
      m_long    <= '0;
      m_repeat  <= '0;
      for (int c = 0; c < N_CH; c++) held[c] <= 0;
    end else begin
      hist.push_back(btn_i);
      for (int c = 0; c < N_CH; c++) begin
        m_level[c]   <= win_bit(c, m_level[c]);
        m_press[c]   <= win_bit(c, m_level[c]) && !m_level[c];
        m_release[c] <= !win_bit(c, m_level[c]) && m_level[c];
        held[c]      <= (win_bit(c, m_level[c]) && m_level[c]) ? held[c] + 1 : 0;
        m_long[c]    <= win_bit(c, m_level[c]) && m_level[c] && (held[c] + 1 == HOLD);
        m_repeat[c]  <= AR && win_bit(c, m_level[c]) && m_level[c] &&
                        (held[c] + 1 > HOLD) && ((held[c] + 1 - HOLD) % REP == 0);
      end
    end
  end

  task automatic idle(input int n);
    btn_i = '0;
    repeat (n) @(negedge clk_i);
  endtask

  // Outputs stay 0 under reset even with all buttons pressed.
  task automatic test_reset();
    btn_i = '1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_i);
      total++;
      if ({level_o, press_o, release_o, long_o, repeat_o} !== 15'd0) begin
        bad++;
        $display("FAIL reset cycle %0d: outputs got %b want 0", n,
                 {level_o, press_o, release_o, long_o, repeat_o});
      end
    end
    btn_i = '0;
    rst_i = 1'b0;
  endtask

  // Clean rise on channel 0: level and press appear LAT cycles later.
  task automatic test_press_latency();
    logic [N_CH-1:0] el, ep;
    btn_i = 3'b001;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_i);
      el = (n >= LAT) ? 3'b001 : 3'b000;
      ep = (n == LAT) ? 3'b001 : 3'b000;
      total++;
      if ({level_o, press_o, release_o, long_o, repeat_o} !== {el, ep, 9'd0}) begin
        bad++;
        $display("FAIL press_latency cycle %0d: lvl/prs/rel/lng/rep got %b/%b/%b/%b/%b want %b/%b/000/000/000",
                 n, level_o, press_o, release_o, long_o, repeat_o, el, ep);
      end
    end
  endtask

  // Channel 1 toggling every 5 cycles never settles.
  task automatic test_bounce();
    btn_i = 3'b010;
    for (int n = 1; n <= 72; n++) begin
      @(negedge clk_i);
      total++;
      if ({level_o[1], press_o[1], release_o[1]} !== 3'b000) begin
        bad++;
        $display("FAIL bounce cycle %0d: ch1 lvl/prs/rel got %b%b%b want 000",
                 n, level_o[1], press_o[1], release_o[1]);
      end
      if (n == 60) btn_i[1] = 1'b0;
      else if (n < 60 && n % 5 == 0) btn_i[1] = ~btn_i[1];
    end
  endtask

  // Channel 2 held 100 cycles: long at press+40, repeats every 10 after.
  task automatic test_long_repeat();
    logic el, ep, er, eg, et;
    btn_i = 3'b100;
    for (int n = 1; n <= 125; n++) begin
      @(negedge clk_i);
      el = (n >= LAT) && (n < 112);
      ep = (n == LAT);
      er = (n == 112);
      eg = (n == LAT + HOLD);
      et = AR && (n > 52) && (n < 112) && ((n - 52) % REP == 0);
      total++;
      if ({level_o, press_o, release_o, long_o, repeat_o} !==
          {el, 2'b00, ep, 2'b00, er, 2'b00, eg, 2'b00, et, 2'b00}) begin
        bad++;
        $display("FAIL long_repeat cycle %0d: lvl/prs/rel/lng/rep got %b/%b/%b/%b/%b want ch2 %b%b%b%b%b",
                 n, level_o, press_o, release_o, long_o, repeat_o, el, ep, er, eg, et);
      end
      if (n == 100) btn_i = 3'b000;
    end
  endtask

  // Release at hold count 20: release_o 12 cycles after the raw fall, no long.
  task automatic test_early_release();
    logic el, ep, er;
    btn_i = 3'b001;
    for (int n = 1; n <= 110; n++) begin
      @(negedge clk_i);
      el = (n >= LAT) && (n < 44);
      ep = (n == LAT);
      er = (n == 44);
      total++;
      if ({level_o, press_o, release_o, long_o, repeat_o} !==
          {2'b00, el, 2'b00, ep, 2'b00, er, 6'd0}) begin
        bad++;
        $display("FAIL early_release cycle %0d: lvl/prs/rel/lng/rep got %b/%b/%b/%b/%b want ch0 %b%b%b00",
                 n, level_o, press_o, release_o, long_o, repeat_o, el, ep, er);
      end
      if (n == LAT + 20) btn_i = 3'b000;
    end
  endtask

  // Reset mid-hold clears outputs at once; held button re-debounces after.
  task automatic test_reset_mid_hold();
    logic el, ep;
    btn_i = 3'b001;
    repeat (30) @(negedge clk_i);
    total++;
    if (level_o !== 3'b001) begin
      bad++;
      $display("FAIL mid_hold_pre: level got %b want 001", level_o);
    end
    #2 rst_i = 1'b1;
    #1;
    total++;
    if ({level_o, press_o, release_o, long_o, repeat_o} !== 15'd0) begin
      bad++;
      $display("FAIL mid_hold_async: outputs got %b want 0",
               {level_o, press_o, release_o, long_o, repeat_o});
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_i);
      el = (n >= LAT);
      ep = (n == LAT);
      total++;
      if ({level_o, press_o, release_o, long_o, repeat_o} !==
          {2'b00, el, 2'b00, ep, 9'd0}) begin
        bad++;
        $display("FAIL mid_hold_after cycle %0d: lvl/prs got %b/%b want ch0 %b/%b",
                 n, level_o, press_o, el, ep);
      end
    end
  endtask

  // All channels rise together: presses coincide.
  task automatic test_simultaneous();
    logic [N_CH-1:0] el, ep;
    btn_i = 3'b111;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk_i);
      el = (n >= LAT) ? 3'b111 : 3'b000;
      ep = (n == LAT) ? 3'b111 : 3'b000;
      total++;
      if ({level_o, press_o, release_o} !== {el, ep, 3'b000}) begin
        bad++;
        $display("FAIL simultaneous cycle %0d: lvl/prs/rel got %b/%b/%b want %b/%b/000",
                 n, level_o, press_o, release_o, el, ep);
      end
    end
  endtask

  // Random bounce/press/hold mix on all channels against the model.
  task automatic test_random();
    int rem[N_CH];
    int sel;
    for (int c = 0; c < N_CH; c++) rem[c] = 1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk_i);
      total++;
      if ({level_o, press_o, release_o, long_o, repeat_o} !==
          {m_level, m_press, m_release, m_long, m_repeat}) begin
        bad++;
        $display("FAIL random cycle %0d: lvl/prs/rel/lng/rep got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                 n, level_o, press_o, release_o, long_o, repeat_o,
                 m_level, m_press, m_release, m_long, m_repeat);
      end
      if (n == 1500) rst_i = 1'b1;
      if (n == 1502) rst_i = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        rem[c]--;
        if (rem[c] <= 0) begin
          btn_i[c] = ~btn_i[c];
          sel = int'($urandom_range(0, 9));
          if (sel < 5)      rem[c] = int'($urandom_range(1, 7));
          else if (sel < 8) rem[c] = int'($urandom_range(9, 30));
          else              rem[c] = int'($urandom_range(40, 110));
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b0;
    btn_i = '0;
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    test_reset();
    idle(5);
    test_press_latency();
    idle(30);
    test_bounce();
    idle(30);
    test_long_repeat();
    idle(30);
    test_early_release();
    idle(30);
    test_reset_mid_hold();
    idle(30);
    test_simultaneous();
    idle(30);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_CH, default 5, number of independent button channels (1..32).
REQ-002 Parameter DEBOUNCE_CYC, default 500_000, stable-input cycles required before the debounced level changes.
REQ-003 Parameter HOLD_CYC, default 50_000_000, held cycles after the debounced rise before long_o fires.
REQ-004 Parameter REPEAT_CYC, default 10_000_000, period of repeat_o pulses after long_o.
REQ-005 clk_i  input  1  single clock; every flop is on its rising edge.
REQ-006 rst_i  input  1  reset, asynchronous, active-high.
REQ-007 btn_i  input  N_CH  raw asynchronous button inputs, one bit per channel.
REQ-008 level_o  output  N_CH  debounced level per channel.
REQ-009 press_o  output  N_CH  one-cycle pulse on a debounced 0->1 transition.
REQ-010 release_o  output  N_CH  one-cycle pulse on a debounced 1->0 transition.
REQ-011 long_o  output  N_CH  one-cycle pulse once per hold, when level_o has been 1 for HOLD_CYC cycles.
REQ-012 repeat_o  output  N_CH  one-cycle auto-repeat pulses (see Configuration).

Function
REQ-013 Each bit of btn_i SHALL pass a 2-flop synchronizer; channels SHALL be fully independent.
REQ-014 Per channel: synchronized sample s and previous sample p; if s!=p then p<=s and ctr<=0; else ctr increments, saturating at DEBOUNCE_CYC.
REQ-015 When ctr==DEBOUNCE_CYC and p!=level_o, level_o SHALL take p on that edge.
REQ-016 Latency: a clean raw edge, held stable, SHALL appear on level_o exactly DEBOUNCE_CYC+4 cycles later.
REQ-017 Any raw toggle before ctr reaches DEBOUNCE_CYC SHALL restart the count, and level_o SHALL NOT change.
REQ-018 press_o/release_o SHALL be registered and asserted in the first cycle in which level_o shows the new value, for exactly one cycle.
REQ-019 A hold counter SHALL clear on press, count while level_o==1, and saturate after HOLD_CYC. long_o SHALL pulse in the cycle the count reaches HOLD_CYC.
REQ-020 A release SHALL clear the hold and repeat counters in the same cycle as release_o. No long_o or repeat_o pulse SHALL coincide with release_o.
REQ-021 Counter widths SHALL be $clog2(max+1) of their own terminal value; counters SHALL never wrap.
REQ-022 Elaboration SHALL fail if N_CH, DEBOUNCE_CYC, HOLD_CYC or REPEAT_CYC is 0, or if HOLD_CYC <= DEBOUNCE_CYC.

Reset
REQ-023 Asserting rst_i SHALL clear synchronizers, p, all counters and all outputs to 0 asynchronously, including mid-debounce or mid-hold.
REQ-024 After rst_i deasserts with a button already held, that channel SHALL debounce normally and emit press_o at DEBOUNCE_CYC+4 cycles.

Configuration
REQ-025 Macro BTN_AUTOREPEAT_EN defined: after long_o, repeat_o SHALL pulse every REPEAT_CYC cycles while held. The first pulse comes REPEAT_CYC cycles after long_o.
REQ-026 Macro BTN_AUTOREPEAT_EN undefined: the repeat counters SHALL be absent and repeat_o SHALL be constant 0.

Structure
REQ-027 Package btn_pkg SHALL hold the default parameter constants and a width function ctr_width(max) returning $clog2(max+1).
REQ-028 Sub-module btn_channel SHALL implement one channel (sync, debounce, edge, hold, repeat). The top SHALL instantiate N_CH copies with a generate loop.

Verification (N_CH=3, DEBOUNCE_CYC=8, HOLD_CYC=40, REPEAT_CYC=10)
REQ-029 btn_i[0] 0->1 held -> level_o[0]=1 and press_o[0] one-cycle pulse 12 cycles later; other channels remain 0.
REQ-030 btn_i[1] toggled every 5 cycles for 60 cycles -> level_o[1], press_o[1] and release_o[1] stay 0 throughout.
REQ-031 btn_i[2] held 100 cycles -> long_o[2] pulse 40 cycles after press_o[2]. With BTN_AUTOREPEAT_EN, repeat_o[2] pulses at +10, +20 and so on; without it, repeat_o stays 0.
REQ-032 Held button released at hold count 20 -> release_o pulse 12 cycles after the raw fall, and no long_o pulse ever fires.
REQ-033 rst_i asserted mid-hold with btn_i[0] still high -> all outputs 0 immediately. After deassertion, press_o[0] pulses 12 cycles later.
REQ-034 Simultaneous raw rise on all 3 channels -> three press_o bits pulse in the same cycle.
